pit_table: RTL and testbench
============================

// Module: pit_table
// PURPOSE
//  Pending Interest Table: the PIT-side responder to the FIB's data-propagation handshake and the
//  source of its outgoing-interest requests. Records pending interests with their requesting faces.
//  Forwards each new prefix to the FIB for longest-prefix match.
//  Answers FIB prefix queries with accept or reject. Streams accepted data to every requesting face.
// PARAMETERS
//  ENTRIES     8     number of PIT entries (table slots)
//  FACES       4     number of interfaces; width of the face bitmap
//  DATA_BYTES  1024  bytes per data packet accepted from the FIB
//  LIFETIME    4096  cycles an unsatisfied entry lives before expiry
// PORTS
//  clk                in   1   clock, rising edge
//  rst                in   1   asynchronous, active-low reset (asserted at 0)
//  interest_valid     in   1   interest present on interest_* this cycle
//  interest_prefix    in   64  interest name prefix
//  interest_len       in   6   interest prefix length
//  interest_face      in   FACES  one-hot arrival face
//  interest_ready     out  1   insert FSM idle; interest accepted when valid&ready
//  interest_drop      out  1   1-cycle pulse: table full, interest discarded
//  pit_in_prefix      out  64  prefix forwarded to FIB outgoing lookup
//  pit_in_len         out  6   length forwarded to FIB
//  fib_out_bit        out  1   1-cycle pulse qualifying pit_in_prefix/pit_in_len
//  pit_out_prefix     in   64  data prefix queried by FIB
//  prefix_ready       in   1   FIB query strobe
//  rejected           out  1   1-cycle pulse: no pending entry for query
//  start_send_to_pit  out  1   1-cycle pulse: entry matched, FIB may stream data
//  fib_data           in   8   data byte from FIB
//  face_data          out  8   byte to faces
//  face_valid         out  1   face_data valid
//  face_mask          out  FACES  faces that receive face_data
//  face_last          out  1   marks final byte (DATA_BYTES-th)
//  entry_expired      out  1   1-cycle pulse: an entry timed out
// BEHAVIOUR
//  Reset (rst=0, async): all entries invalid; all outputs 0 except interest_ready=1; both FSMs in IDLE.
//  Entry contents: valid, locked, prefix[63:0], len[5:0], faces[FACES-1:0], age[$clog2(LIFETIME+1)-1:0].
//  Insert FSM: IDLE -> SEARCH -> UPDATE -> IDLE.
//   IDLE: interest_ready=1. On valid&ready, latch the interest and go to SEARCH.
//   SEARCH: compare the latched prefix against all valid, unlocked entries, full 64-bit equality.
//           Snapshot the free bitmap in the same cycle.
//   UPDATE, hit:  OR interest_face into the entry's faces; reset age to 0. No FIB forward.
//   UPDATE, miss with a free slot: allocate the lowest-index free slot; faces=interest_face; age=0.
//           Same cycle: fib_out_bit=1; pit_in_prefix/pit_in_len driven from the latched values.
//   UPDATE, miss with table full: interest_drop=1; table unchanged.
//   Latency: valid&ready to fib_out_bit/interest_drop = 2 cycles. Accepted-interest throughput is one per 3 cycles.
//  Data FSM: IDLE -> LOOKUP -> RESPOND -> RECEIVE -> IDLE.
//   IDLE: on prefix_ready, latch pit_out_prefix and go to LOOKUP.
//   LOOKUP: match against valid, unlocked entries; lowest index wins.
//   RESPOND, hit:  pulse start_send_to_pit; set the entry's locked bit; latch its faces; go to RECEIVE.
//   RESPOND, miss: pulse rejected; go to IDLE.
//   RECEIVE: the first byte arrives on fib_data the cycle after the start_send_to_pit pulse.
//            One byte per cycle, exactly DATA_BYTES bytes, counted by a 10-bit byte counter.
//            face_data = fib_data registered (1-cycle latency); face_valid=1; face_mask = latched faces.
//            face_last=1 with the final byte; in that same cycle the entry is cleared (valid=0, locked=0).
//  prefix_ready outside IDLE is ignored; no response is generated for it.
//  Ageing: age of every valid, unlocked entry increments each cycle.
//   When age reaches LIFETIME-1 the entry is cleared and entry_expired pulses.
//   Several entries expiring in one cycle produce a single pulse.
//   Locked entries do not age. Aggregation in the same cycle as expiry wins: entry kept, age reset.
//  Concurrency:
//   An entry freed in the same cycle as an UPDATE is not reused until the next SEARCH.
//   Allocation and RESPOND lock on different entries in one cycle both take effect.
//   An interest whose prefix matches only a locked entry allocates a new entry.
//  Reset mid-packet: all entries, counters and outputs return to reset values immediately.
// TESTING
//  Empty table; interest A=64'h1234 len 16 face 4'b0001 -> fib_out_bit pulse 2 cycles later, pit_in_prefix=64'h1234, pit_in_len=16.
//  Second interest A on face 4'b0100 -> no fib_out_bit; FIB query A -> start_send_to_pit; 1024 bytes 0..255 repeating appear on face_data with face_mask=4'b0101, face_last on byte 1024; entry freed.
//  Query for unknown prefix 64'hBEEF -> rejected pulse 2 cycles after prefix_ready; no face_valid.
//  Fill all 8 entries with distinct prefixes; 9th distinct interest -> interest_drop, no fib_out_bit.
//  LIFETIME=16: insert, no data -> entry_expired 16 cycles after allocation; later query of that prefix -> rejected.
//  Reset asserted at byte 500 of RECEIVE -> face_valid=0 at once; after release, query of that prefix -> rejected.

Source files
------------

// File: rtl/pit_table_if.sv
// Handshake and data bundle between the pending interest table and its neighbours (ingress, FIB, faces).
// The slave modport is the table's view; master is the environment driving it.
interface pit_table_if #(
  parameter int FACES = 4
);
  logic             interest_valid;
  logic [63:0]      interest_prefix;
  logic [5:0]       interest_len;
  logic [FACES-1:0] interest_face;
  logic             interest_ready;
  logic             interest_drop;
  logic [63:0]      pit_in_prefix;
  logic [5:0]       pit_in_len;
  logic             fib_out_bit;
  logic [63:0]      pit_out_prefix;
  logic             prefix_ready;
  logic             rejected;
  logic             start_send_to_pit;
  logic [7:0]       fib_data;
  logic [7:0]       face_data;
  logic             face_valid;
  logic [FACES-1:0] face_mask;
  logic             face_last;
  logic             entry_expired;

  modport slave (
    input  interest_valid, interest_prefix, interest_len, interest_face,
    input  pit_out_prefix, prefix_ready, fib_data,
    output interest_ready, interest_drop, pit_in_prefix, pit_in_len, fib_out_bit,
    output rejected, start_send_to_pit, face_data, face_valid, face_mask, face_last,
    output entry_expired
  );

  modport master (
    output interest_valid, interest_prefix, interest_len, interest_face,
    output pit_out_prefix, prefix_ready, fib_data,
    input  interest_ready, interest_drop, pit_in_prefix, pit_in_len, fib_out_bit,
    input  rejected, start_send_to_pit, face_data, face_valid, face_mask, face_last,
    input  entry_expired
  );
endinterface

// File: rtl/pit_table.sv
// Pending Interest Table: aggregates interests per prefix, forwards new prefixes to the FIB,
// answers FIB data queries and fans accepted data out to every requesting face.
module pit_table #(
  parameter int ENTRIES    = 8,
  parameter int FACES      = 4,
  parameter int DATA_BYTES = 1024,
  parameter int LIFETIME   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  pit_table_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int AGE_W = $clog2(LIFETIME + 1);
  localparam int CNT_W = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {I_IDLE, I_SEARCH, I_UPDATE} ins_state_t;
  typedef enum logic [1:0] {D_IDLE, D_LOOKUP, D_RESPOND, D_RECEIVE} dat_state_t;

  ins_state_t ins_state, ins_next;
  dat_state_t dat_state, dat_next;

  logic [ENTRIES-1:0] ent_valid, ent_locked;
  logic [63:0]        ent_prefix [ENTRIES];
  logic [FACES-1:0]   ent_faces  [ENTRIES];
  logic [AGE_W-1:0]   ent_age    [ENTRIES];

  logic [63:0]        in_prefix_p0;
  logic [5:0]         in_len_p0;
  logic [FACES-1:0]   in_face_p0;
  logic               hit_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [ENTRIES-1:0] free_p1;

  logic [63:0]        q_prefix_p0;
  logic               dhit_p1;
  logic [IDX_W-1:0]   didx_p1;
  logic [FACES-1:0]   send_faces;
  logic [CNT_W-1:0]   byte_cnt;

  logic [7:0]         face_data_p2;
  logic [FACES-1:0]   face_mask_p2;
  logic               face_vld_p2;
  logic               face_last_p2;

  logic [ENTRIES-1:0] ins_match, dat_match, expiring, agg_vec, lock_vec, expire_now;
  logic               agg_ok, alloc, drop, respond_ok, reject, last_byte;
  logic [IDX_W-1:0]   alloc_idx;

  function automatic logic [IDX_W-1:0] lowest(input logic [ENTRIES-1:0] v);
    lowest = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (v[i]) lowest = IDX_W'(i);
  endfunction

  always_comb begin
    ins_match = '0;
    dat_match = '0;
    expiring  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ins_match[i] = ent_valid[i] && !ent_locked[i] && (ent_prefix[i] == in_prefix_p0);
      dat_match[i] = ent_valid[i] && !ent_locked[i] && (ent_prefix[i] == q_prefix_p0);
      expiring[i]  = ent_valid[i] && !ent_locked[i] && (ent_age[i] == AGE_W'(LIFETIME - 1));
    end
  end

  // Insert FSM; the SEARCH snapshot is revalidated in UPDATE in case the entry expired or got locked.
  always_comb begin
    ins_next = ins_state;
    agg_ok   = 1'b0;
    alloc    = 1'b0;
    drop     = 1'b0;
    case (ins_state)
      I_IDLE:   if (bus.interest_valid) ins_next = I_SEARCH;
      I_SEARCH: ins_next = I_UPDATE;
      I_UPDATE: begin
        ins_next = I_IDLE;
        agg_ok   = hit_p1 && ent_valid[idx_p1] && !ent_locked[idx_p1];
        alloc    = !agg_ok && (|free_p1);
        drop     = !agg_ok && !(|free_p1);
      end
      default:  ins_next = I_IDLE;
    endcase
  end

  assign alloc_idx = lowest(free_p1);

  always_comb begin
    dat_next   = dat_state;
    respond_ok = 1'b0;
    reject     = 1'b0;
    last_byte  = 1'b0;
    case (dat_state)
      D_IDLE:    if (bus.prefix_ready) dat_next = D_LOOKUP;
      D_LOOKUP:  dat_next = D_RESPOND;
      D_RESPOND: begin
        respond_ok = dhit_p1 && ent_valid[didx_p1] && !ent_locked[didx_p1];
        reject     = !respond_ok;
        dat_next   = respond_ok ? D_RECEIVE : D_IDLE;
      end
      D_RECEIVE: begin
        last_byte = (byte_cnt == CNT_W'(DATA_BYTES - 1));
        if (last_byte) dat_next = D_IDLE;
      end
      default:   dat_next = D_IDLE;
    endcase
  end

  always_comb begin
    agg_vec  = '0;
    lock_vec = '0;
    if (agg_ok)     agg_vec[idx_p1]   = 1'b1;
    if (respond_ok) lock_vec[didx_p1] = 1'b1;
    // Aggregating or locking an entry on its last cycle of life keeps it alive.
    expire_now = expiring & ~agg_vec & ~lock_vec;
  end

  // Stage p0/p1: interest latch and search snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins_state    <= I_IDLE;
      in_prefix_p0 <= '0;
      in_len_p0    <= '0;
      in_face_p0   <= '0;
      hit_p1       <= 1'b0;
      idx_p1       <= '0;
      free_p1      <= '0;
    end else begin
      ins_state <= ins_next;
      if (ins_state == I_IDLE && bus.interest_valid) begin
        in_prefix_p0 <= bus.interest_prefix;
        in_len_p0    <= bus.interest_len;
        in_face_p0   <= bus.interest_face;
      end
      if (ins_state == I_SEARCH) begin
        hit_p1  <= |ins_match;
        idx_p1  <= lowest(ins_match);
        free_p1 <= ~ent_valid;
      end
    end
  end

  // Stage p0/p1: query latch and lookup result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_state   <= D_IDLE;
      q_prefix_p0 <= '0;
      dhit_p1     <= 1'b0;
      didx_p1     <= '0;
      send_faces  <= '0;
      byte_cnt    <= '0;
    end else begin
      dat_state <= dat_next;
      if (dat_state == D_IDLE && bus.prefix_ready) q_prefix_p0 <= bus.pit_out_prefix;
      if (dat_state == D_LOOKUP) begin
        dhit_p1 <= |dat_match;
        didx_p1 <= lowest(dat_match);
      end
      if (respond_ok) begin
        send_faces <= ent_faces[didx_p1] | ((agg_ok && idx_p1 == didx_p1) ? in_face_p0 : '0);
        byte_cnt   <= '0;
      end else if (dat_state == D_RECEIVE) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Stage p2: registered byte toward the faces.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      face_vld_p2  <= 1'b0;
      face_data_p2 <= '0;
      face_mask_p2 <= '0;
      face_last_p2 <= 1'b0;
    end else begin
      face_vld_p2  <= (dat_state == D_RECEIVE);
      face_data_p2 <= (dat_state == D_RECEIVE) ? bus.fib_data : '0;
      face_mask_p2 <= (dat_state == D_RECEIVE) ? send_faces : '0;
      face_last_p2 <= last_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid  <= '0;
      ent_locked <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc && alloc_idx == IDX_W'(i)) begin
          ent_valid[i]  <= 1'b1;
          ent_locked[i] <= 1'b0;
        end else if (last_byte && didx_p1 == IDX_W'(i)) begin
          ent_valid[i]  <= 1'b0;
          ent_locked[i] <= 1'b0;
        end else begin
          if (expire_now[i]) ent_valid[i]  <= 1'b0;
          if (lock_vec[i])   ent_locked[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (alloc && alloc_idx == IDX_W'(i)) begin
        ent_prefix[i] <= in_prefix_p0;
        ent_faces[i]  <= in_face_p0;
        ent_age[i]    <= '0;
      end else if (agg_vec[i]) begin
        ent_faces[i] <= ent_faces[i] | in_face_p0;
        ent_age[i]   <= '0;
      end else if (ent_valid[i] && !ent_locked[i]) begin
        ent_age[i] <= ent_age[i] + AGE_W'(1);
      end
    end
  end

  assign bus.interest_ready    = (ins_state == I_IDLE);
  assign bus.interest_drop     = drop;
  assign bus.fib_out_bit       = alloc;
  assign bus.pit_in_prefix     = in_prefix_p0;
  assign bus.pit_in_len        = in_len_p0;
  assign bus.rejected          = reject;
  assign bus.start_send_to_pit = respond_ok;
  assign bus.face_data         = face_data_p2;
  assign bus.face_valid        = face_vld_p2;
  assign bus.face_mask         = face_mask_p2;
  assign bus.face_last         = face_last_p2;
  assign bus.entry_expired     = |expire_now;
endmodule

// File: tb/tb_pit_table.sv
// Directed bench for pit_table: interest table vectors, data streaming, expiry and reset corners.
module tb_pit_table;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pit_table_if #(.FACES(4)) bus1();
  pit_table_if #(.FACES(4)) bus2();

  pit_table dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  pit_table #(.LIFETIME(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] prefix;
    logic [5:0]  len;
    logic [3:0]  face;
    logic        fob;
    logic        drop;
  } ivec_t;

  ivec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input ivec_t v, input string tag);
    bus1.interest_valid  = 1'b1;
    bus1.interest_prefix = v.prefix;
    bus1.interest_len    = v.len;
    bus1.interest_face   = v.face;
    tick();
    bus1.interest_valid = 1'b0;
    check({tag, "_ready_busy"}, bus1.interest_ready, 0);
    tick();
    check({tag, "_fib_out_bit"}, bus1.fib_out_bit, v.fob);
    check({tag, "_drop"}, bus1.interest_drop, v.drop);
    if (v.fob) begin
      check({tag, "_pit_in_prefix"}, bus1.pit_in_prefix, v.prefix);
      check({tag, "_pit_in_len"}, bus1.pit_in_len, v.len);
    end
    tick();
    check({tag, "_ready_back"}, bus1.interest_ready, 1);
  endtask

  task automatic query1(input logic [63:0] p, input string tag, output logic st, output logic rj);
    bus1.pit_out_prefix = p;
    bus1.prefix_ready   = 1'b1;
    tick();
    bus1.prefix_ready = 1'b0;
    check({tag, "_early_resp"}, {bus1.rejected, bus1.start_send_to_pit}, 0);
    tick();
    st = bus1.start_send_to_pit;
    rj = bus1.rejected;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic st, rj;
    int nvalid, ngood, nlast, lastpos, n;

    tbl[0]  = '{64'h1234, 6'd16, 4'b0001, 1'b1, 1'b0};
    tbl[1]  = '{64'h1234, 6'd16, 4'b0100, 1'b0, 1'b0};
    tbl[2]  = '{64'hA001, 6'd33, 4'b0001, 1'b1, 1'b0};
    tbl[3]  = '{64'hA002, 6'd34, 4'b0010, 1'b1, 1'b0};
    tbl[4]  = '{64'hA003, 6'd35, 4'b0100, 1'b1, 1'b0};
    tbl[5]  = '{64'hA004, 6'd36, 4'b1000, 1'b1, 1'b0};
    tbl[6]  = '{64'hA005, 6'd37, 4'b0001, 1'b1, 1'b0};
    tbl[7]  = '{64'hA006, 6'd38, 4'b0010, 1'b1, 1'b0};
    tbl[8]  = '{64'hA007, 6'd39, 4'b0100, 1'b1, 1'b0};
    tbl[9]  = '{64'hA008, 6'd40, 4'b0001, 1'b0, 1'b1};
    tbl[10] = '{64'h8000_0000_0000_1234, 6'd16, 4'b0001, 1'b0, 1'b1};
    tbl[11] = '{64'hA001, 6'd33, 4'b0010, 1'b0, 1'b0};

    rst = 1'b0;
    bus1.interest_valid = 0; bus1.interest_prefix = 0; bus1.interest_len = 0; bus1.interest_face = 0;
    bus1.pit_out_prefix = 0; bus1.prefix_ready = 0; bus1.fib_data = 0;
    bus2.interest_valid = 0; bus2.interest_prefix = 0; bus2.interest_len = 0; bus2.interest_face = 0;
    bus2.pit_out_prefix = 0; bus2.prefix_ready = 0; bus2.fib_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_interest_ready", bus1.interest_ready, 1);
    check("rst_fib_out_bit", bus1.fib_out_bit, 0);
    check("rst_face_valid", bus1.face_valid, 0);
    check("rst_resp", {bus1.rejected, bus1.start_send_to_pit, bus1.interest_drop}, 0);
    check("rst_expired", bus1.entry_expired, 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) send1(tbl[i], $sformatf("ins%0d", i));

    // Stream for prefix A, aggregated on faces 0 and 2.
    query1(64'h1234, "qA", st, rj);
    check("qA_start", st, 1);
    check("qA_rejected", rj, 0);
    nvalid = 0; ngood = 0; nlast = 0; lastpos = -1;
    for (int k = 0; k <= 1024; k++) begin
      tick();
      if (bus1.face_valid) begin
        nvalid++;
        if (bus1.face_data == 8'((k - 1) & 255) && bus1.face_mask == 4'b0101) ngood++;
        if (bus1.face_last) begin
          nlast++;
          lastpos = k - 1;
        end
      end
      if (k < 1024) bus1.fib_data = 8'(k & 255);
    end
    check("streamA_valid_count", nvalid, 1024);
    check("streamA_good_bytes", ngood, 1024);
    check("streamA_last_count", nlast, 1);
    check("streamA_last_pos", lastpos, 1023);
    tick();
    check("streamA_valid_after", bus1.face_valid, 0);

    query1(64'h1234, "qA2", st, rj);
    check("qA2_rejected", rj, 1);
    check("qA2_start", st, 0);
    tick();
    send1('{64'hC0DE, 6'd20, 4'b1000, 1'b1, 1'b0}, "insC");

    query1(64'hBEEF, "qBEEF", st, rj);
    check("qBEEF_rejected", rj, 1);
    check("qBEEF_start", st, 0);
    tick();
    check("qBEEF_no_valid", bus1.face_valid, 0);
    tick();
    check("qBEEF_no_valid2", bus1.face_valid, 0);

    // Expiry with LIFETIME=16.
    bus2.interest_valid = 1; bus2.interest_prefix = 64'hCAFE; bus2.interest_len = 8; bus2.interest_face = 4'b0010;
    tick();
    bus2.interest_valid = 0;
    tick();
    check("exp_alloc", bus2.fib_out_bit, 1);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus2.entry_expired) begin
        n = c;
        break;
      end
    end
    check("exp_cycles", n, 16);
    tick();
    check("exp_single_pulse", bus2.entry_expired, 0);
    bus2.pit_out_prefix = 64'hCAFE; bus2.prefix_ready = 1;
    tick();
    bus2.prefix_ready = 0;
    tick();
    check("exp_query_rejected", bus2.rejected, 1);
    tick();

    // Aggregation landing on the expiry cycle keeps the entry and restarts its age.
    bus2.interest_valid = 1; bus2.interest_prefix = 64'hF00D; bus2.interest_face = 4'b0001;
    tick();
    bus2.interest_valid = 0;
    tick();
    check("agx_alloc", bus2.fib_out_bit, 1);
    repeat (14) tick();
    bus2.interest_valid = 1; bus2.interest_face = 4'b0100;
    tick();
    bus2.interest_valid = 0;
    tick();
    check("agx_agg_no_fob", bus2.fib_out_bit, 0);
    check("agx_no_expire", bus2.entry_expired, 0);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus2.entry_expired) begin
        n = c;
        break;
      end
    end
    check("agx_expire_cycles", n, 16);

    // Reset in the middle of a packet.
    query1(64'hA001, "qB1", st, rj);
    check("qB1_start", st, 1);
    for (int k = 0; k <= 500; k++) begin
      tick();
      if (k == 1) check("qB1_mask", {bus1.face_valid, bus1.face_mask}, 5'b1_0011);
      bus1.fib_data = 8'(k & 255);
    end
    check("pre_reset_valid", bus1.face_valid, 1);
    rst = 1'b0;
    #1;
    check("midrst_face_valid", bus1.face_valid, 0);
    check("midrst_face_mask", bus1.face_mask, 0);
    check("midrst_ready", bus1.interest_ready, 1);
    #1;
    rst = 1'b1;
    tick();
    query1(64'hA001, "qB1r", st, rj);
    check("post_rst_rejected", rj, 1);
    tick();
    query1(64'hA002, "qB2r", st, rj);
    check("post_rst_rejected2", rj, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
